// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Purpose:
//   Sequencer for the "set the time" interaction of a watch. A long press of
//   key 2 while in watch mode opens a setting session. Key 1 walks the
//   selected digit 0..3 and commits after the last digit. Key 2 requests an
//   increment of the selected digit. The selected digit blinks while nobody
//   touches the keys. An idle session commits on its own after a timeout.
//   Leaving watch mode abandons the session without committing.
//
// Optional feature (compile-time macro TIME_SET_AUTO_REPEAT_EN):
//   When defined, a long press of key 2 inside a session issues an increment
//   and then keeps issuing one every REPEAT_DIV cycles while key 2 stays held.
//   When undefined, a long press inside a session is ignored and no repeat
//   counter exists.
//
// Parameters:
//   BLINK_DIV   clk cycles per blink half-period
//   REPEAT_DIV  clk cycles between auto-repeat increments
//   TIMEOUT_CYC idle clk cycles in a session before auto-commit
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   mode_watch   high while the top level is in watch mode
//   key_first_1  one-cycle short-press pulse, key 1
//   key_first_2  one-cycle short-press pulse, key 2
//   key_long_2   one-cycle long-press pulse, key 2
//   key_held_2   level, key 2 currently pressed
//   setting      high while a setting session is live
//   digit_sel    selected digit 0..3
//   inc_pulse    one-cycle increment strobe
//   inc_digit    digit targeted by the most recent increment strobe
//   blink_off    high when the selected digit is blanked
//   commit       one-cycle pulse when the new time is committed
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int unsigned BLINK_DIV   = 32'd25_000_000,
    parameter int unsigned REPEAT_DIV  = 32'd10_000_000,
    parameter int unsigned TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_watch,
    input  logic       key_first_1,
    input  logic       key_first_2,
    input  logic       key_long_2,
    input  logic       key_held_2,
    output logic       setting,
    output logic [1:0] digit_sel,
    output logic       inc_pulse,
    output logic [1:0] inc_digit,
    output logic       blink_off,
    output logic       commit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SET    = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [31:0] BLINK_LAST = BLINK_DIV - 32'd1;
    localparam logic [31:0] REP_LAST   = REPEAT_DIV - 32'd1;
    localparam logic [31:0] TMO_LAST   = TIMEOUT_CYC - 32'd1;

    state_e      state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic        inc_pulse_q, inc_pulse_d;
    logic [1:0]  inc_digit_q, inc_digit_d;
    logic        blink_off_q, blink_off_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        setting_q, setting_d;
    logic        commit_q, commit_d;

    logic        key_evt_s;
    logic        inc_req_s;
    logic        rep_fire_s;
    logic        tmo_expire_s;
    logic        session_live_s;

`ifdef TIME_SET_AUTO_REPEAT_EN
    logic        rep_on_q, rep_on_d;
    logic [31:0] rep_cnt_q, rep_cnt_d;
`else
    // Without auto-repeat the held level and repeat period have no consumer.
    logic [32:0] unused_s;
    assign unused_s = {key_held_2, REP_LAST};
`endif

    // Next-state, counter and output decisions for the setting session
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        inc_pulse_d  = 1'b0;
        inc_digit_d  = inc_digit_q;
        blink_off_d  = blink_off_q;
        blink_cnt_d  = blink_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        key_evt_s    = 1'b0;
        inc_req_s    = 1'b0;
        rep_fire_s   = 1'b0;
        tmo_expire_s = 1'b0;
`ifdef TIME_SET_AUTO_REPEAT_EN
        rep_on_d     = rep_on_q;
        rep_cnt_d    = rep_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                digit_d = 2'd0;
                if (key_long_2 && mode_watch) begin
                    state_d = ST_SET;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SET: begin
                if (!mode_watch) begin
                    // Abort wins over every key seen in the same cycle.
                    state_d = ST_IDLE;
                    digit_d = 2'd0;
                end else begin
`ifdef TIME_SET_AUTO_REPEAT_EN
                    key_evt_s = key_first_1 | key_first_2 | key_long_2;
                    if (key_long_2) begin
                        rep_on_d  = 1'b1;
                        rep_cnt_d = 32'd0;
                        inc_req_s = 1'b1;
                    end else if (rep_on_q && key_held_2) begin
                        if (rep_cnt_q == REP_LAST) begin
                            rep_cnt_d  = 32'd0;
                            rep_fire_s = 1'b1;
                            inc_req_s  = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 32'd1;
                        end
                    end else begin
                        // Releasing key 2 stops repeating in that very cycle.
                        rep_on_d  = 1'b0;
                        rep_cnt_d = 32'd0;
                    end
`else
                    key_evt_s = key_first_1 | key_first_2;
`endif
                    inc_req_s = inc_req_s | key_first_2;

                    // Increment targets the selection before any key 1 advance.
                    if (inc_req_s) begin
                        inc_pulse_d = 1'b1;
                        inc_digit_d = digit_q;
                    end else begin
                        inc_pulse_d = 1'b0;
                    end

                    if (key_evt_s || rep_fire_s) begin
                        tmo_cnt_d = 32'd0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_cnt_d    = 32'd0;
                        tmo_expire_s = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end

                    // Key activity keeps the digit visible and restarts the phase.
                    if (key_evt_s) begin
                        blink_cnt_d = 32'd0;
                        blink_off_d = 1'b0;
                    end else if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = 32'd0;
                        blink_off_d = ~blink_off_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 32'd1;
                    end

                    if (key_first_1) begin
                        if (digit_q == 2'd3) begin
                            state_d = ST_COMMIT;
                        end else begin
                            digit_d = digit_q + 2'd1;
                        end
                    end else if (tmo_expire_s) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_SET;
                    end
                end
            end

            ST_COMMIT: begin
                state_d = ST_IDLE;
                digit_d = 2'd0;
            end

            default: begin
                state_d = ST_IDLE;
                digit_d = 2'd0;
            end
        endcase

        // Blink, timeout and repeat state only survive while the session stays live.
        session_live_s = (state_d == ST_SET);
        blink_off_d    = blink_off_d & session_live_s;
        blink_cnt_d    = session_live_s ? blink_cnt_d : 32'd0;
        tmo_cnt_d      = session_live_s ? tmo_cnt_d : 32'd0;
`ifdef TIME_SET_AUTO_REPEAT_EN
        rep_on_d       = rep_on_d & session_live_s;
        rep_cnt_d      = session_live_s ? rep_cnt_d : 32'd0;
`endif

        setting_d = session_live_s;
        commit_d  = (state_d == ST_COMMIT);
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            digit_q     <= 2'd0;
            inc_pulse_q <= 1'b0;
            inc_digit_q <= 2'd0;
            blink_off_q <= 1'b0;
            blink_cnt_q <= 32'd0;
            tmo_cnt_q   <= 32'd0;
            setting_q   <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            inc_pulse_q <= inc_pulse_d;
            inc_digit_q <= inc_digit_d;
            blink_off_q <= blink_off_d;
            blink_cnt_q <= blink_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            setting_q   <= setting_d;
            commit_q    <= commit_d;
        end
    end

`ifdef TIME_SET_AUTO_REPEAT_EN
    // Auto-repeat registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_on_q  <= 1'b0;
            rep_cnt_q <= 32'd0;
        end else begin
            rep_on_q  <= rep_on_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign setting   = setting_q;
    assign digit_sel = digit_q;
    assign inc_pulse = inc_pulse_q;
    assign inc_digit = inc_digit_q;
    assign blink_off = blink_off_q;
    assign commit    = commit_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Self-checking bench for time_set_ctrl with BLINK_DIV=4, REPEAT_DIV=3,
// TIMEOUT_CYC=20. A behavioural model tracks the session in terms of
// "edges since the last key" and "edges since the long press", and derives
// the expected outputs from those ages with plain arithmetic. Directed
// scenarios pin the model with literal expectations; a randomized phase
// then exercises the rest. Expectations follow TIME_SET_AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

    localparam int BLINK = 4;
    localparam int REP   = 3;
    localparam int TMO   = 20;
`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       mode_watch;
    logic       key_first_1;
    logic       key_first_2;
    logic       key_long_2;
    logic       key_held_2;
    logic       setting;
    logic [1:0] digit_sel;
    logic       inc_pulse;
    logic [1:0] inc_digit;
    logic       blink_off;
    logic       commit;

    time_set_ctrl #(
        .BLINK_DIV   (32'd4),
        .REPEAT_DIV  (32'd3),
        .TIMEOUT_CYC (32'd20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_watch  (mode_watch),
        .key_first_1 (key_first_1),
        .key_first_2 (key_first_2),
        .key_long_2  (key_long_2),
        .key_held_2  (key_held_2),
        .setting     (setting),
        .digit_sel   (digit_sel),
        .inc_pulse   (inc_pulse),
        .inc_digit   (inc_digit),
        .blink_off   (blink_off),
        .commit      (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: 0 = idle, 1 = session live, 2 = commit cycle.
    int m_mode      = 0;
    int m_sel       = 0;
    int m_inc_dig   = 0;
    int m_blink_age = 0;   // edges in session since entry or last key
    int m_quiet     = 0;   // edges in session since entry, last key or repeat
    int m_rep_age   = 0;   // edges since the long press that started repeating
    bit m_rep_on    = 1'b0;
    bit m_inc       = 1'b0;

    task automatic model_step();
        bit evt;
        bit inc;
        bit fire;
        bit done;
        m_inc = 1'b0;
        if (rst) begin
            m_mode = 0; m_sel = 0; m_inc_dig = 0;
            m_blink_age = 0; m_quiet = 0; m_rep_on = 1'b0;
        end else if (m_mode == 0) begin
            if (key_long_2 && mode_watch) begin
                m_mode = 1; m_sel = 0; m_blink_age = 0; m_quiet = 0; m_rep_on = 1'b0;
            end
        end else if (m_mode == 2) begin
            m_mode = 0; m_sel = 0;
        end else if (!mode_watch) begin
            m_mode = 0; m_sel = 0;
        end else begin
            evt  = key_first_1 || key_first_2 || (AR && key_long_2);
            inc  = key_first_2;
            fire = 1'b0;
            done = 1'b0;
            if (AR) begin
                if (key_long_2) begin
                    m_rep_on = 1'b1; m_rep_age = 0; inc = 1'b1;
                end else if (m_rep_on && key_held_2) begin
                    m_rep_age++;
                    if (m_rep_age % REP == 0) begin
                        inc = 1'b1; fire = 1'b1;
                    end
                end else begin
                    m_rep_on = 1'b0;
                end
            end
            if (inc) begin
                m_inc = 1'b1; m_inc_dig = m_sel;
            end
            if (evt || fire) m_quiet = 0;
            else begin
                m_quiet++;
                done = (m_quiet >= TMO);
            end
            if (evt) m_blink_age = 0;
            else m_blink_age++;
            if (key_first_1) begin
                if (m_sel == 3) done = 1'b1;
                else m_sel++;
            end
            if (done) m_mode = 2;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle compare against the model.
    task automatic compare_all();
        vectors++;
        chk("setting",   int'(setting),   (m_mode == 1) ? 1 : 0);
        chk("digit_sel", int'(digit_sel), m_sel);
        chk("inc_pulse", int'(inc_pulse), int'(m_inc));
        chk("inc_digit", int'(inc_digit), m_inc_dig);
        chk("blink_off", int'(blink_off),
            ((m_mode == 1) && (((m_blink_age / BLINK) % 2) == 1)) ? 1 : 0);
        chk("commit",    int'(commit),    (m_mode == 2) ? 1 : 0);
    endtask

    // Hand-computed literal expectation.
    task automatic lit(input string name, input int act, input int exp);
        vectors++;
        chk(name, act, exp);
    endtask

    // Apply one clock edge worth of inputs, then check the result.
    task automatic step(input logic f1, input logic f2, input logic l2);
        key_first_1 = f1;
        key_first_2 = f2;
        key_long_2  = l2;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic enter();
        mode_watch = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        lit("enter_setting", int'(setting), 1);
        lit("enter_digit", int'(digit_sel), 0);
    endtask

    task automatic abort();
        mode_watch = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        mode_watch = 1'b1;
    endtask

    initial begin
        rst = 1'b1; mode_watch = 1'b1; key_held_2 = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        lit("rst_setting", int'(setting), 0);
        lit("rst_digit", int'(digit_sel), 0);
        lit("rst_inc", int'(inc_pulse), 0);
        lit("rst_inc_digit", int'(inc_digit), 0);
        lit("rst_blink", int'(blink_off), 0);
        lit("rst_commit", int'(commit), 0);
        rst = 1'b0;

        // Walk all four digits and commit.
        enter();
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            lit("walk_digit", int'(digit_sel), k);
        end
        step(1'b1, 1'b0, 1'b0);
        lit("walk_commit", int'(commit), 1);
        lit("walk_commit_setting", int'(setting), 0);
        step(1'b0, 1'b0, 1'b0);
        lit("walk_commit_once", int'(commit), 0);
        lit("walk_idle_digit", int'(digit_sel), 0);

        // Simultaneous advance and increment at digit 2.
        enter();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        lit("both_inc", int'(inc_pulse), 1);
        lit("both_inc_digit", int'(inc_digit), 2);
        lit("both_digit", int'(digit_sel), 3);
        step(1'b0, 1'b0, 1'b0);
        lit("both_inc_once", int'(inc_pulse), 0);
        abort();
        lit("abort_setting", int'(setting), 0);

        // Timeout commit after 20 quiet cycles.
        enter();
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 1'b0);
            lit("timeout_commit", int'(commit), (k == 20) ? 1 : 0);
        end
        step(1'b0, 1'b0, 1'b0);
        lit("timeout_idle", int'(setting), 0);

        // Abort at cycle 5 never commits.
        enter();
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b0);
        mode_watch = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        lit("abort5_setting", int'(setting), 0);
        lit("abort5_inc", int'(inc_pulse), 0);
        mode_watch = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b0);
            lit("abort5_commit", int'(commit), 0);
        end

        // Blink phase and restart on a key.
        enter();
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, 1'b0);
            lit("blink_phase", int'(blink_off), (k >= 4) ? 1 : 0);
        end
        step(1'b0, 1'b1, 1'b0);
        lit("blink_key_clear", int'(blink_off), 0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 1'b0);
            lit("blink_restart", int'(blink_off), (k == 4) ? 1 : 0);
        end
        abort();

        // Long press in a session: repeats only when the feature is built.
        enter();
        key_held_2 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 10) key_held_2 = 1'b0;
            step(1'b0, 1'b0, (k == 0) ? 1'b1 : 1'b0);
            lit("repeat_pulse", int'(inc_pulse),
                (AR && (k % 3 == 0) && (k <= 9)) ? 1 : 0);
        end
        abort();

        // Reset mid-session and in the commit cycle.
        enter();
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        lit("rst_mid_digit", int'(digit_sel), 0);
        lit("rst_mid_setting", int'(setting), 0);
        rst = 1'b0;
        enter();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0);
        lit("pre_rst_commit", int'(commit), 1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        lit("rst_commit_commit", int'(commit), 0);
        lit("rst_commit_setting", int'(setting), 0);
        lit("rst_commit_digit", int'(digit_sel), 0);
        lit("rst_commit_blink", int'(blink_off), 0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        lit("idle_inc_ignored", int'(inc_pulse), 0);
        step(1'b1, 1'b0, 1'b0);
        lit("idle_f1_ignored", int'(digit_sel), 0);

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            mode_watch = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 7) == 0) key_held_2 = ~key_held_2;
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25_000_000, meaning clk cycles per blink half-period.
REQ-002 SHALL have parameter REPEAT_DIV, default 10_000_000, meaning clk cycles between auto-repeat increments.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 500_000_000, meaning idle clk cycles in setting before auto-commit; internal counters 32 bits.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mode_watch  input  1  high while the top level is in watch mode.
REQ-007 SHALL have ports key_first_1, key_first_2  input  1 each  one-cycle short-press pulses.
REQ-008 SHALL have port key_long_2  input  1  one-cycle long-press pulse, key 2.
REQ-009 SHALL have port key_held_2  input  1  level, key 2 currently pressed.
REQ-010 SHALL have port setting  output  1  high while in setting mode (drives led_setting).
REQ-011 SHALL have port digit_sel  output  2  selected digit 0..3 (drives Hex_bit).
REQ-012 SHALL have ports inc_pulse  output  1  and inc_digit  output  2  one-cycle increment strobe plus target digit.
REQ-013 SHALL have port blink_off  output  1  high = selected digit blanked.
REQ-014 SHALL have port commit  output  1  one-cycle pulse when new time is committed.

Function
REQ-015 SHALL implement states IDLE, SET, COMMIT; setting=1 only in SET.
REQ-016 IDLE: key_long_2 && mode_watch -> SET next cycle, digit_sel=0, blink_off=0, all counters cleared.
REQ-017 SET: key_first_1 with digit_sel<3 -> digit_sel+1; with digit_sel==3 -> COMMIT (no wrap).
REQ-018 SET: key_first_2 -> inc_pulse=1 and inc_digit=digit_sel (pre-update value) on next cycle; latency exactly 1.
REQ-019 SET: mode_watch low -> IDLE next cycle without commit (abort); highest priority, same-cycle keys ignored.
REQ-020 SET: timeout counter reaching TIMEOUT_CYC-1 with no key_first_*/key_long_2 event -> COMMIT; any such event reloads it to 0.
REQ-021 COMMIT: commit=1 for exactly one cycle, then IDLE with digit_sel=0, setting=0.
REQ-022 Same-cycle key_first_1 and key_first_2 in SET: increment targets old digit_sel, selection advances.
REQ-023 blink_off SHALL toggle every BLINK_DIV cycles in SET; any key event clears blink counter and forces blink_off=0; blink_off=0 outside SET.
REQ-024 inc_pulse SHALL never assert outside SET-originated events; key inputs in IDLE other than REQ-016 are ignored.

Reset
REQ-025 rst SHALL force IDLE, setting=0, digit_sel=0, inc_pulse=0, inc_digit=0, blink_off=0, commit=0, all counters 0, on the next clk edge, including mid-SET or in COMMIT (no commit pulse emitted).

Configuration
REQ-026 Macro TIME_SET_AUTO_REPEAT_EN defined: in SET, key_long_2 -> inc_pulse next cycle, then one inc_pulse every REPEAT_DIV cycles while key_held_2=1; repeat stops the cycle key_held_2=0; each repeat reloads timeout.
REQ-027 Macro undefined: key_long_2 in SET is ignored; no repeat counter is built.

Verification (BLINK_DIV=4, REPEAT_DIV=3, TIMEOUT_CYC=20)
REQ-028 rst, then key_long_2 with mode_watch=1 -> setting=1, digit_sel=0 next cycle; four key_first_1 -> digit_sel 1,2,3 then commit=1 one cycle, setting=0.
REQ-029 In SET digit_sel=2, key_first_1 and key_first_2 same cycle -> inc_pulse=1, inc_digit=2, digit_sel=3 one cycle later.
REQ-030 In SET, no keys for 20 cycles -> commit pulse; mode_watch dropped instead at cycle 5 -> IDLE, commit stays 0.
REQ-031 In SET idle -> blink_off toggles every 4 cycles; key_first_2 mid-phase -> blink_off=0, counter restarts.
REQ-032 With TIME_SET_AUTO_REPEAT_EN, key_long_2 then key_held_2 high 10 cycles -> inc_pulse at +1, +4, +7, +10; without macro -> no inc_pulse.
REQ-033 rst asserted in COMMIT cycle -> commit=0 next cycle, state IDLE, outputs at reset values.
